// File: rtl/hub75_bcm_scheduler_if.sv
// Shift handshake between the BCM scheduler (master) and the column shifter (slave).
// The shifter must hold shift_ack low unless it is completing the request currently shown.
interface hub75_bcm_scheduler_if #(
    parameter int RW = 5,
    parameter int PW = 3
);
    logic          shift_req;
    logic [RW-1:0] shift_row;
    logic [PW-1:0] shift_plane;
    logic          shift_ack;

    modport master (
        output shift_req,
        output shift_row,
        output shift_plane,
        input  shift_ack
    );

    modport slave (
        input  shift_req,
        input  shift_row,
        input  shift_plane,
        output shift_ack
    );
endinterface

// File: rtl/hub75_bcm_scheduler.sv
// HUB-75 binary-code-modulation scan scheduler: walks (row, plane) slots, fetches each
// slot through the shift handshake and lights plane p for base << p cycles.
//
// state        | meaning
// S_IDLE       | panel blanked, slot pointer parked at (0,0)
// S_FILL       | first fetch of (0,0) after enable, nothing displayed yet
// S_BLANK      | oe high, new slot address on abcd/plane, lat on the last cycle
// S_SHOW       | oe low for the weighted period, next slot being fetched
// S_WAIT_SHIFT | period over but next slot not yet shifted in, oe high
module hub75_bcm_scheduler #(
    parameter int k_scan_rows      = 32,
    parameter int k_bit_depth      = 6,
    parameter int k_base_on_cycles = 8,
    parameter int k_blank_cycles   = 2,
    localparam int RW = $clog2(k_scan_rows),
    localparam int PW = (k_bit_depth > 1) ? $clog2(k_bit_depth) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    hub75_bcm_scheduler_if.master shift_if,
    output logic [RW-1:0]         abcd,
    output logic [PW-1:0]         plane,
    output logic                  lat,
    output logic                  oe,
    output logic                  frame_start
);

    localparam int MAX_ON = k_base_on_cycles << (k_bit_depth - 1);
    localparam int TMAX   = (MAX_ON > k_blank_cycles) ? MAX_ON : k_blank_cycles;
    localparam int TW     = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [TW-1:0] BLANK_LOAD = TW'(k_blank_cycles - 1);
    localparam logic [PW-1:0] LAST_PLANE = PW'(k_bit_depth - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_SHOW,
        S_WAIT_SHIFT,
        S_BLANK
    } state_t;

    state_t        state_q;
    logic [TW-1:0] timer_q;
    logic          ready_q;
    logic          shift_req_q;
    logic [RW-1:0] shift_row_q;
    logic [PW-1:0] shift_plane_q;
    logic [RW-1:0] abcd_q;
    logic [PW-1:0] plane_q;
    logic          lat_q;
    logic          oe_q;
    logic          frame_start_q;
    logic          ack_now;

    // Down-counter load for a lit period; the timer expires on the cycle it reads zero.
    function automatic logic [TW-1:0] on_load(input logic [PW-1:0] p);
        int n;
        n = (k_base_on_cycles << p) - 1;
        return n[TW-1:0];
    endfunction

    // Acks without an outstanding request are ignored.
    assign ack_now = shift_req_q && shift_if.shift_ack;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_IDLE;
            timer_q       <= '0;
            ready_q       <= 1'b0;
            shift_req_q   <= 1'b0;
            shift_row_q   <= '0;
            shift_plane_q <= '0;
            abcd_q        <= '0;
            plane_q       <= '0;
            lat_q         <= 1'b0;
            oe_q          <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            lat_q         <= 1'b0;
            frame_start_q <= 1'b0;
            if (ack_now) begin
                shift_req_q <= 1'b0;
                ready_q     <= 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    oe_q          <= 1'b1;
                    ready_q       <= 1'b0;
                    shift_row_q   <= '0;
                    shift_plane_q <= '0;
                    if (enable) state_q <= S_FILL;
                end

                S_FILL: begin
                    if (ack_now) begin
                        state_q <= S_BLANK;
                        abcd_q  <= shift_row_q;
                        plane_q <= shift_plane_q;
                        timer_q <= BLANK_LOAD;
                        ready_q <= 1'b0;
                        oe_q    <= 1'b1;
                    end else begin
                        shift_req_q <= 1'b1;
                    end
                end

                S_BLANK: begin
                    if (timer_q == '0) begin
                        state_q     <= S_SHOW;
                        oe_q        <= 1'b0;
                        timer_q     <= on_load(plane_q);
                        shift_req_q <= 1'b1;
                        if (plane_q == LAST_PLANE) begin
                            shift_plane_q <= '0;
                            shift_row_q   <= abcd_q + 1'b1;
                        end else begin
                            shift_plane_q <= plane_q + 1'b1;
                            shift_row_q   <= abcd_q;
                        end
                    end else begin
                        timer_q <= timer_q - 1'b1;
                        if (timer_q == TW'(1)) begin
                            lat_q         <= 1'b1;
                            frame_start_q <= (abcd_q == '0) && (plane_q == '0);
                        end
                    end
                end

                S_SHOW: begin
                    if (timer_q != '0) begin
                        timer_q <= timer_q - 1'b1;
                    end else begin
                        oe_q <= 1'b1;
                        if ((ready_q || ack_now) && enable) begin
                            state_q <= S_BLANK;
                            abcd_q  <= shift_row_q;
                            plane_q <= shift_plane_q;
                            timer_q <= BLANK_LOAD;
                            ready_q <= 1'b0;
                        end else if (shift_req_q && !ack_now) begin
                            state_q <= S_WAIT_SHIFT;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end

                S_WAIT_SHIFT: begin
                    oe_q <= 1'b1;
                    if (ack_now) begin
                        if (enable) begin
                            state_q <= S_BLANK;
                            abcd_q  <= shift_row_q;
                            plane_q <= shift_plane_q;
                            timer_q <= BLANK_LOAD;
                            ready_q <= 1'b0;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign shift_if.shift_req   = shift_req_q;
    assign shift_if.shift_row   = shift_row_q;
    assign shift_if.shift_plane = shift_plane_q;
    assign abcd                 = abcd_q;
    assign plane                = plane_q;
    assign lat                  = lat_q;
    assign oe                   = oe_q;
    assign frame_start          = frame_start_q;

endmodule

// File: tb/tb_hub75_bcm_scheduler.sv
// Self-checking bench for hub75_bcm_scheduler: a delay-programmable shifter model acks
// requests, and each displayed slot is checked against slot-order and timing arithmetic.
module tb_hub75_bcm_scheduler;

    localparam int R     = 4;
    localparam int B     = 2;
    localparam int BASE  = 4;
    localparam int BLANK = 2;
    localparam int FRAME = R * (BASE * ((1 << B) - 1) + B * BLANK);

    logic       clk;
    logic       rst;
    logic       en;
    logic [1:0] abcd;
    logic       pl;
    logic       lat;
    logic       oe;
    logic       fs;

    int cyc       = 0;
    int errors    = 0;
    int checks    = 0;
    int ack_delay = 2;
    int spur_cnt  = 0;
    int fs_q[$];
    int dly[0:79];

    hub75_bcm_scheduler_if #(.RW(2), .PW(1)) sif ();

    hub75_bcm_scheduler #(
        .k_scan_rows     (R),
        .k_bit_depth     (B),
        .k_base_on_cycles(BASE),
        .k_blank_cycles  (BLANK)
    ) dut (
        .clock      (clk),
        .reset      (rst),
        .enable     (en),
        .shift_if   (sif),
        .abcd       (abcd),
        .plane      (pl),
        .lat        (lat),
        .oe         (oe),
        .frame_start(fs)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Shifter model: acks ack_delay cycles after a request is first seen; extra pulses on demand.
    initial begin
        int  cnt;
        bit  busy;
        int  spur_done;
        cnt = 0;
        busy = 0;
        spur_done = 0;
        sif.shift_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            sif.shift_ack = 1'b0;
            if (rst) begin
                busy = 0;
            end else begin
                if (!busy && sif.shift_req === 1'b1) begin
                    busy = 1;
                    cnt  = ack_delay;
                end
                if (busy) begin
                    if (cnt == 0) begin
                        sif.shift_ack = 1'b1;
                        busy = 0;
                    end else begin
                        cnt--;
                    end
                end
            end
            if (spur_cnt != spur_done) begin
                sif.shift_ack = 1'b1;
                spur_done++;
            end
        end
    end

    function automatic int exp_row(input int k);
        return (k / B) % R;
    endfunction

    function automatic int exp_pl(input int k);
        return k % B;
    endfunction

    function automatic int exp_on(input int k);
        return BASE << exp_pl(k);
    endfunction

    function automatic int exp_gap(input int d, input int on);
        return BLANK + ((d - on + 1 > 0) ? (d - on + 1) : 0);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req"},   32'(sif.shift_req),   0);
        chk({tag, "_srow"},  32'(sif.shift_row),   0);
        chk({tag, "_splane"},32'(sif.shift_plane), 0);
        chk({tag, "_abcd"},  32'(abcd),            0);
        chk({tag, "_plane"}, 32'(pl),              0);
        chk({tag, "_lat"},   32'(lat),             0);
        chk({tag, "_oe"},    32'(oe),              1);
        chk({tag, "_fs"},    32'(fs),              0);
    endtask

    // Enters at a negedge with the DUT idle; leaves at the negedge of the first lit cycle of (0,0).
    task automatic start_scan(input int d0, input int d1);
        int n;
        int lat_cnt;
        int lat_n;
        int fs_cnt;
        ack_delay = d0;
        en = 1'b1;
        @(negedge clk);
        chk("fill_req_early", 32'(sif.shift_req), 0);
        @(negedge clk);
        chk("fill_req",       32'(sif.shift_req),   1);
        chk("fill_req_row",   32'(sif.shift_row),   0);
        chk("fill_req_plane", 32'(sif.shift_plane), 0);
        ack_delay = d1;
        n = 2;
        lat_cnt = 0;
        lat_n = -1;
        fs_cnt = 0;
        for (int i = 0; i < 200; i++) begin
            if (oe !== 1'b1) break;
            if (lat === 1'b1) begin
                lat_cnt++;
                lat_n = n;
            end
            if (fs === 1'b1) fs_cnt++;
            @(negedge clk);
            n++;
        end
        chk("start_latency", n, 5 + d0);
        chk("start_lat_cnt", lat_cnt, 1);
        chk("start_lat_pos", lat_n, n - 1);
        chk("start_fs",      fs_cnt, 1);
    endtask

    // Enters at the negedge of the first lit cycle of slot k; leaves at the first lit cycle of k+1.
    task automatic do_slot(input int k, input int d_cur, input int d_next,
                           input int drop_at, input int spur_at, input bit spur_gap);
        int nk;
        int on;
        int len;
        int bad;
        int g;
        int lat_cnt;
        int lat_pos;
        int lat_row;
        int fs_cnt;
        int lows;
        nk = k + 1;
        on = exp_on(k);
        chk("show_req",       32'(sif.shift_req),   1);
        chk("show_req_row",   32'(sif.shift_row),   exp_row(nk));
        chk("show_req_plane", 32'(sif.shift_plane), exp_pl(nk));
        chk("show_abcd",      32'(abcd),            exp_row(k));
        chk("show_plane",     32'(pl),              exp_pl(k));
        ack_delay = d_next;
        len = 1;
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            if (len == drop_at) en = 1'b0;
            if (len == spur_at) spur_cnt++;
            @(negedge clk);
            if (oe !== 1'b0) break;
            if (32'(abcd) !== 32'(exp_row(k)) || 32'(pl) !== 32'(exp_pl(k))) bad++;
            len++;
        end
        chk("on_len",      len, on);
        chk("addr_stable", bad, 0);
        if (drop_at > 0) begin
            lows = 0;
            lat_cnt = 0;
            for (int i = 0; i < 30; i++) begin
                if (oe !== 1'b1) lows++;
                if (lat !== 1'b0) lat_cnt++;
                @(negedge clk);
            end
            chk("drop_oe_low",   lows, 0);
            chk("drop_lat",      lat_cnt, 0);
            chk("drop_req_done", 32'(sif.shift_req), 0);
            return;
        end
        g = 0;
        lat_cnt = 0;
        lat_pos = -1;
        lat_row = -1;
        fs_cnt = 0;
        for (int i = 0; i < 300; i++) begin
            if (oe !== 1'b1) break;
            if (lat === 1'b1) begin
                lat_cnt++;
                lat_pos = g;
                lat_row = int'(abcd);
            end
            if (fs === 1'b1) begin
                fs_cnt++;
                fs_q.push_back(cyc);
            end
            if (spur_gap && g == 0) spur_cnt++;
            @(negedge clk);
            g++;
        end
        chk("gap",         g, exp_gap(d_cur, on));
        chk("lat_count",   lat_cnt, 1);
        chk("lat_pos",     lat_pos, g - 1);
        chk("lat_abcd",    lat_row, exp_row(nk));
        chk("frame_start", fs_cnt, (nk % (R * B) == 0) ? 1 : 0);
    endtask

    initial begin
        int period;
        int d0;
        rst = 1'b1;
        en  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_reset_vals("rst_hold");
        end
        rst = 1'b0;
        en  = 1'b0;
        @(negedge clk);
        chk("idle_oe",  32'(oe), 1);
        chk("idle_req", 32'(sif.shift_req), 0);

        // Steady, slow, on-the-edge and random shifter delays, then (2,1) for the enable drop.
        for (int k = 0; k < 16; k++) dly[k] = 2;
        for (int k = 16; k < 20; k++) dly[k] = 12;
        dly[20] = BASE - 1;
        dly[21] = 2 * BASE - 1;
        dly[22] = BASE;
        dly[23] = 2 * BASE;
        for (int k = 24; k < 69; k++) dly[k] = int'($urandom_range(0, 14));
        dly[69] = 12;
        for (int k = 70; k < 80; k++) dly[k] = 0;

        start_scan(2, dly[0]);
        fs_q.delete();
        for (int k = 0; k < 69; k++) begin
            do_slot(k, dly[k], dly[k + 1], 0, (k == 15) ? 5 : 0, k == 15);
            if (k == 15) begin
                chk("fs_pulses", fs_q.size(), 2);
                period = (fs_q.size() >= 2) ? (fs_q[1] - fs_q[0]) : -1;
                chk("frame_period", period, FRAME);
            end
        end
        do_slot(69, dly[69], 0, 3, 0, 1'b0);

        d0 = int'($urandom_range(0, 6));
        for (int k = 0; k < 7; k++) dly[k] = int'($urandom_range(0, 14));
        start_scan(d0, dly[0]);
        for (int k = 0; k < 5; k++) do_slot(k, dly[k], dly[k + 1], 0, 0, 1'b0);

        rst = 1'b1;
        @(negedge clk);
        chk_reset_vals("rst_mid");
        @(negedge clk);
        chk_reset_vals("rst_mid2");
        rst = 1'b0;
        en  = 1'b0;
        @(negedge clk);
        chk("post_rst_oe",  32'(oe), 1);
        chk("post_rst_req", 32'(sif.shift_req), 0);
        start_scan(1, 2);
        do_slot(0, 2, 2, 0, 0, 1'b0);
        do_slot(1, 2, 2, 0, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
